addsub_rr_scheduler: RTL and testbench
======================================

Name: addsub_rr_scheduler

Overview:
Shares one N-bit add/subtract datapath among NREQ requesters. Each requester uses a valid/ready request handshake. A round-robin arbiter grants one request at a time, and the block latches its operands. The shared adder (existing n_bit_adder, driven as y^sub with cin=sub) computes the result, which is returned through a single tagged valid/ready response channel. The block sits between requesting control FSMs and the arithmetic datapath.

Parameters:
N, 4, operand/result width in bits (>=2)
NREQ, 4, number of requesters (>=2, power of two)
IDW, 2, requester-ID width = clog2(NREQ)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept, one-hot or zero
req_x  input  NREQ*N  flattened operand x; requester i uses bits [i*N +: N]
req_y  input  NREQ*N  flattened operand y, same packing
req_sub  input  NREQ  per-requester op: 0 = x+y, 1 = x-y
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  IDW  index of the requester that owns the response
rsp_f  output  N  result x+y or x-y, modulo 2^N
rsp_cout  output  1  adder carry-out; for subtract, 1 = no borrow (x>=y unsigned)
rsp_ov  output  1  two's-complement signed overflow

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. On reset: state=IDLE, rr_ptr=0, operand/op/id registers=0, rsp_valid=0, rsp_f=0, rsp_cout=0, rsp_ov=0, rsp_id=0, req_ready=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... (mod NREQ).
  - req_ready[g] is asserted combinationally in the same cycle. This is the transfer cycle.
  - On the clock edge: latch x, y, sub and id=g, then go to EXEC.
  - If no req_valid is set, stay in IDLE; req_ready=0.
- EXEC:
  - The adder sees the latched operands: yeff = y XOR {N{sub}}, cin = sub.
  - On the clock edge: register f, cout and ov into the rsp_* registers, set rsp_valid=1, go to RESP.
  - ov = (x[N-1] & yeff[N-1] & ~f[N-1]) | (~x[N-1] & ~yeff[N-1] & f[N-1]), computed in this block.
- RESP:
  - rsp_* outputs are held stable while rsp_valid=1 and rsp_ready=0.
  - When rsp_ready=1: transfer occurs, rsp_valid clears next edge, rr_ptr <= (id+1) mod NREQ, go to IDLE.
  - rsp_ready may be high before rsp_valid; it is ignored outside RESP.
- Timing: latency is request transfer at edge T, rsp_valid high after edge T+1, i.e. 2 cycles. Minimum occupancy is 3 cycles per operation.
- req_ready is 0 in EXEC and RESP. Requests are never dropped: a requester holds req_valid and its operands until it sees req_ready.
- Fairness: a requester waits at most NREQ-1 other grants. rr_ptr advances only on response transfer.
- rr_ptr wraps from NREQ-1 to 0.
- Operand changes on req_x/req_y after the transfer have no effect.
- Reset asserted mid-operation aborts the transaction: no response is issued, outputs return to reset values immediately.

Decomposition:
- Package addsub_sched_pkg: state enum {IDLE, EXEC, RESP}; localparam OP_ADD=0, OP_SUB=1.
- Sub-module rr_arbiter (NREQ): inputs req vector and ptr; outputs one-hot grant, grant index and any-valid. Purely combinational.
- The datapath is an instance of n_bit_adder with N. The scheduler owns operand inversion and ov.

Test Plan:
- N=4. Req0: x=3, y=4, sub=0 -> rsp_f=7, cout=0, ov=0, id=0; rsp_valid 2 cycles after the transfer.
- Req2: x=5, y=3, sub=1 -> f=2, cout=1, ov=0. Then x=3, y=5, sub=1 -> f=4'hE, cout=0, ov=0.
- Overflow: x=7, y=1, add -> f=8, ov=1, cout=0. x=8, y=1, sub -> f=7, ov=1, cout=1.
- All four req_valid held high, rsp_ready=1 -> grants in order 0,1,2,3,0. Deassert req1 -> order skips to 2 after 0.
- rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, all req_ready=0. Release -> next grant goes to the following requester.
- rst_n low during EXEC -> rsp_valid stays 0, rr_ptr=0. After release, the pending req3 is granted with its original operands.

Source files
------------

// File: rtl/addsub_sched_pkg.sv
// Shared types and helpers for the round-robin add/subtract scheduler.
// Holds the FSM state encoding, op codes and the signed-overflow helper.
package addsub_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Signed overflow from the operand MSBs and the result MSB (yeff is post-inversion).
    function automatic logic add_ov(input logic x_msb, input logic yeff_msb, input logic f_msb);
        return (x_msb & yeff_msb & ~f_msb) | (~x_msb & ~yeff_msb & f_msb);
    endfunction

endpackage

// File: rtl/n_bit_adder.sv
// Plain N-bit ripple-style adder with carry in and carry out.
module n_bit_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    // Widen by one bit so the carry falls out of the top of the sum.
    always_comb begin
        {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or after ptr wins.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gidx,
    output logic            any
);

    // Walk the requesters from ptr upward; power-of-two NREQ makes the index wrap for free.
    always_comb begin
        logic [IDW-1:0] idx_s;
        grant = {NREQ{1'b0}};
        gidx  = {IDW{1'b0}};
        any   = 1'b0;
        idx_s = {IDW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            idx_s = ptr + k[IDW-1:0];
            if (!any && req[idx_s]) begin
                any          = 1'b1;
                gidx         = idx_s;
                grant[idx_s] = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/addsub_rr_scheduler.sv
// Shares one add/subtract datapath among NREQ requesters with round-robin grant
// and returns tagged results on a single valid/ready response channel.
module addsub_rr_scheduler
    import addsub_sched_pkg::*;
#(
    parameter int N    = 4,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_x,
    input  logic [NREQ*N-1:0] req_y,
    input  logic [NREQ-1:0]   req_sub,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_f,
    output logic              rsp_cout,
    output logic              rsp_ov
);

    state_e          state_r;
    logic [IDW-1:0]  rr_ptr_r;
    logic [IDW-1:0]  id_r;
    logic [N-1:0]    x_r;
    logic [N-1:0]    y_r;
    logic            sub_r;
    logic            rsp_valid_r;
    logic [IDW-1:0]  rsp_id_r;
    logic [N-1:0]    rsp_f_r;
    logic            rsp_cout_r;
    logic            rsp_ov_r;

    logic [NREQ-1:0] grant_s;
    logic [IDW-1:0]  gidx_s;
    logic            any_s;
    logic [N-1:0]    sel_x_s;
    logic [N-1:0]    sel_y_s;
    logic            sel_sub_s;
    logic [N-1:0]    yeff_s;
    logic [N-1:0]    sum_s;
    logic            cout_s;
    logic            ov_s;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_r),
        .grant (grant_s),
        .gidx  (gidx_s),
        .any   (any_s)
    );

    // Operand mux for the granted requester, sampled only on the transfer edge.
    always_comb begin
        sel_x_s   = req_x[gidx_s*N +: N];
        sel_y_s   = req_y[gidx_s*N +: N];
        sel_sub_s = req_sub[gidx_s];
    end

    // Subtract is x + ~y + 1; the inversion and overflow live here, not in the adder.
    always_comb begin
        yeff_s = y_r ^ {N{sub_r}};
        ov_s   = add_ov(x_r[N-1], yeff_s[N-1], sum_s[N-1]);
    end

    n_bit_adder #(.N(N)) u_adder (
        .a    (x_r),
        .b    (yeff_s),
        .cin  (sub_r),
        .s    (sum_s),
        .cout (cout_s)
    );

    // Accept only in IDLE, and never while reset is held.
    always_comb begin
        if ((state_r == IDLE) && rst_n) begin
            req_ready = grant_s;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    // Main sequencer: grant/latch, execute, then hold the response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rr_ptr_r    <= {IDW{1'b0}};
            id_r        <= {IDW{1'b0}};
            x_r         <= {N{1'b0}};
            y_r         <= {N{1'b0}};
            sub_r       <= OP_ADD;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {IDW{1'b0}};
            rsp_f_r     <= {N{1'b0}};
            rsp_cout_r  <= 1'b0;
            rsp_ov_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        x_r     <= sel_x_s;
                        y_r     <= sel_y_s;
                        sub_r   <= sel_sub_s;
                        id_r    <= gidx_s;
                        state_r <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_f_r     <= sum_s;
                    rsp_cout_r  <= cout_s;
                    rsp_ov_r    <= ov_s;
                    rsp_id_r    <= id_r;
                    rsp_valid_r <= 1'b1;
                    state_r     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        rr_ptr_r    <= id_r + {{(IDW-1){1'b0}}, 1'b1};
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_f     = rsp_f_r;
    assign rsp_cout  = rsp_cout_r;
    assign rsp_ov    = rsp_ov_r;

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Directed self-checking bench for addsub_rr_scheduler (N=4, NREQ=4).
module tb_addsub_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = 4'b0;
    logic [3:0]  req_ready;
    logic [15:0] req_x = 16'h0;
    logic [15:0] req_y = 16'h0;
    logic [3:0]  req_sub = 4'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_f;
    logic        rsp_cout;
    logic        rsp_ov;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    addsub_rr_scheduler #(.N(4), .NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_f     (rsp_f),
        .rsp_cout  (rsp_cout),
        .rsp_ov    (rsp_ov)
    );

    // Issue one request, scramble its operands after transfer, capture the response.
    task automatic run_op(input int i, input logic [3:0] x, input logic [3:0] y, input logic s,
                          output logic [3:0] f, output logic c, output logic o,
                          output logic [1:0] id, output int lat);
        int n;
        @(negedge clk);
        req_valid[i]      = 1'b1;
        req_x[i*4 +: 4]   = x;
        req_y[i*4 +: 4]   = y;
        req_sub[i]        = s;
        #1;
        n = 0;
        while (req_ready[i] !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        f = 4'hx; c = 1'bx; o = 1'bx; id = 2'bxx; lat = -1;
        if (n < 20) begin
            @(posedge clk); #1;
            req_valid[i]    = 1'b0;
            req_x[i*4 +: 4] = ~x;
            req_y[i*4 +: 4] = ~y;
            req_sub[i]      = ~s;
            lat = 0;
            while (rsp_valid !== 1'b1 && lat < 20) begin
                @(negedge clk); lat++;
            end
            f = rsp_f; c = rsp_cout; o = rsp_ov; id = rsp_id;
            if (rsp_ready) begin
                @(posedge clk); #1;
            end
        end else begin
            req_valid[i] = 1'b0;
        end
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        #2;
        checks++;
        if ({rsp_valid, rsp_id, rsp_f, rsp_cout, rsp_ov, req_ready} !== 13'b0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b id=%0d f=%h c=%b ov=%b ready=%b exp all zero",
                     rsp_valid, rsp_id, rsp_f, rsp_cout, rsp_ov, req_ready);
        end
        @(negedge clk);
        req_valid = 4'h0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0) begin
            errors++;
            $display("FAIL idle_no_req ready got %b exp 0000", req_ready);
        end
    endtask

    task automatic test_add();
        logic [3:0] f; logic c, o; logic [1:0] id; int lat;
        run_op(0, 4'd3, 4'd4, 1'b0, f, c, o, id, lat);
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL add_latency got %0d exp 2", lat);
        end
        checks++;
        if ({id, f, c, o} !== {2'd0, 4'd7, 1'b0, 1'b0}) begin
            errors++; $display("FAIL add_3_4 got id=%0d f=%h c=%b ov=%b exp id=0 f=7 c=0 ov=0", id, f, c, o);
        end
    endtask

    task automatic test_sub();
        logic [3:0] f; logic c, o; logic [1:0] id; int lat;
        run_op(2, 4'd5, 4'd3, 1'b1, f, c, o, id, lat);
        checks++;
        if ({id, f, c, o} !== {2'd2, 4'd2, 1'b1, 1'b0} || lat !== 2) begin
            errors++; $display("FAIL sub_5_3 got id=%0d f=%h c=%b ov=%b lat=%0d exp id=2 f=2 c=1 ov=0 lat=2", id, f, c, o, lat);
        end
        run_op(2, 4'd3, 4'd5, 1'b1, f, c, o, id, lat);
        checks++;
        if ({id, f, c, o} !== {2'd2, 4'hE, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sub_3_5 got id=%0d f=%h c=%b ov=%b exp id=2 f=e c=0 ov=0", id, f, c, o);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] f; logic c, o; logic [1:0] id; int lat;
        run_op(0, 4'd7, 4'd1, 1'b0, f, c, o, id, lat);
        checks++;
        if ({id, f, c, o} !== {2'd0, 4'd8, 1'b0, 1'b1}) begin
            errors++; $display("FAIL ov_add_7_1 got id=%0d f=%h c=%b ov=%b exp id=0 f=8 c=0 ov=1", id, f, c, o);
        end
        run_op(1, 4'd8, 4'd1, 1'b1, f, c, o, id, lat);
        checks++;
        if ({id, f, c, o} !== {2'd1, 4'd7, 1'b1, 1'b1}) begin
            errors++; $display("FAIL ov_sub_8_1 got id=%0d f=%h c=%b ov=%b exp id=1 f=7 c=1 ov=1", id, f, c, o);
        end
    endtask

    task automatic test_round_robin();
        int exp_g[7] = '{0, 1, 2, 3, 0, 2, 3};
        int n;
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 4'hF;
        req_x = 16'h3210;
        req_y = 16'h1111;
        req_sub = 4'h0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1;
            n = 0;
            while (req_ready === 4'b0 && n < 20) begin
                @(negedge clk); #1; n++;
            end
            checks++;
            if (req_ready !== (4'b0001 << exp_g[k])) begin
                errors++; $display("FAIL rr_grant_%0d got %b exp index %0d", k, req_ready, exp_g[k]);
            end
            @(posedge clk); #1;
            if (k == 4) req_valid[1] = 1'b0;
        end
        req_valid = 4'h0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        logic [3:0] f; logic c, o; logic [1:0] id; int lat;
        rsp_ready = 1'b0;
        run_op(0, 4'd6, 4'd5, 1'b0, f, c, o, id, lat);
        checks++;
        if ({id, f, c, o} !== {2'd0, 4'hB, 1'b0, 1'b1}) begin
            errors++; $display("FAIL bp_add_6_5 got id=%0d f=%h c=%b ov=%b exp id=0 f=b c=0 ov=1", id, f, c, o);
        end
        req_valid[1] = 1'b1; req_x[7:4] = 4'd1; req_y[7:4] = 4'd1; req_sub[1] = 1'b0;
        req_valid[2] = 1'b1; req_x[11:8] = 4'd2; req_y[11:8] = 4'd2; req_sub[2] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_id, rsp_f, rsp_cout, rsp_ov, req_ready} !== {1'b1, 2'd0, 4'hB, 1'b0, 1'b1, 4'b0}) begin
                errors++;
                $display("FAIL bp_hold_%0d got valid=%b id=%0d f=%h c=%b ov=%b ready=%b exp 1/0/b/0/1/0000",
                         k, rsp_valid, rsp_id, rsp_f, rsp_cout, rsp_ov, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release_valid got %b exp 0", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_next_grant got %b exp 0010", req_ready);
        end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        req_valid[2] = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid[3] = 1'b1; req_x[15:12] = 4'd9; req_y[15:12] = 4'd2; req_sub[3] = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++; $display("FAIL rm_grant got %b exp 1000", req_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_f, req_ready, dut.rr_ptr_r} !== 11'b0) begin
            errors++;
            $display("FAIL rm_abort got valid=%b f=%h ready=%b ptr=%0d exp all zero",
                     rsp_valid, rsp_f, req_ready, dut.rr_ptr_r);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
            errors++; $display("FAIL rm_regrant got valid=%b ready=%b exp 0 1000", rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        req_y[15:12] = 4'hF;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_f, rsp_cout, rsp_ov} !== {1'b1, 2'd3, 4'd7, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL rm_result got valid=%b id=%0d f=%h c=%b ov=%b exp 1/3/7/1/1",
                     rsp_valid, rsp_id, rsp_f, rsp_cout, rsp_ov);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_round_robin();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
